vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DIV, 2: clk cycles per pixel (>=1)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- HS_POL, 0: hsync asserted level
- VS_POL, 0: vsync asserted level
- CNT_W, 10: col/row counter width
- ADDR_W, 20: pixel address width
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: system clock
- n_rst, in, 1: asynchronous active-low reset
- enable, in, 1: run/hold
- pixel_en, out, 1: one-clk pixel strobe
- col_cnt, out, CNT_W: current column
- row_cnt, out, CNT_W: current line
- hsync, out, 1: horizontal sync
- vsync, out, 1: vertical sync
- de, out, 1: active video
- h_state, out, 2: horizontal region
- pixel_addr, out, ADDR_W: linear frame address
- line_end, out, 1: last pixel of line strobe
- frame_end, out, 1: last pixel of frame strobe
REQ-003 Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; defaults give 800 x 525.

Function
REQ-004 Divider SHALL count 0..DIV-1 while enable=1 and assert pixel_en for exactly one clk when it equals DIV-1; DIV=1 SHALL give pixel_en=enable.
REQ-005 enable=0 SHALL freeze the divider, all counters and pixel_addr, and force pixel_en=0; decoded outputs SHALL hold.
REQ-006 On pixel_en, col_cnt SHALL increment, wrapping H_TOTAL-1 -> 0.
REQ-007 row_cnt SHALL increment only on pixel_en with col_cnt=H_TOTAL-1, wrapping V_TOTAL-1 -> 0.
REQ-008 h_state SHALL be an FSM: ACTIVE(0) -> FRONT(1) at col H_ACTIVE, -> SYNC(2) at H_ACTIVE+H_FP, -> BACK(3) at H_ACTIVE+H_FP+H_SYNC, -> ACTIVE at 0; a zero-length region SHALL be skipped.
REQ-009 hsync SHALL equal HS_POL while h_state=SYNC, else ~HS_POL.
REQ-010 vsync SHALL equal VS_POL while row_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~VS_POL.
REQ-011 de SHALL be 1 iff col_cnt<H_ACTIVE and row_cnt<V_ACTIVE.
REQ-012 hsync, vsync, de, h_state SHALL decode the current counter values in the same cycle, with no added latency.
REQ-013 During de, pixel_addr SHALL equal row_cnt*H_ACTIVE+col_cnt, advancing by 1 on each pixel_en, no multiplier; it SHALL hold in blanking and clear to 0 on the frame wrap.
REQ-014 line_end SHALL be pixel_en AND col_cnt=H_TOTAL-1; frame_end SHALL be line_end AND row_cnt=V_TOTAL-1.
REQ-015 Counter arithmetic SHALL be unsigned, and CNT_W must hold H_TOTAL-1 and V_TOTAL-1; the implementation SHALL fail elaboration otherwise.

Reset
REQ-016 n_rst=0 SHALL asynchronously clear divider, col_cnt, row_cnt, pixel_addr, pixel_en, line_end and frame_end.
REQ-017 At reset h_state=ACTIVE, de=1, hsync=~HS_POL, vsync=~VS_POL.
REQ-018 Reset mid-frame SHALL restart at col 0, row 0 on the first pixel_en after release, with no partial-frame state retained.

Verification
Small config: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), DIV=2, pols 0.
REQ-019 Reset, enable=1 -> pixel_en every 2nd clk; col_cnt 0..7 wraps; line_end once per 16 clk.
REQ-020 Count one line -> h_state 0,0,0,0,1,2,2,3; hsync low for col 5-6 only; de high for col 0-3 of rows 0-2.
REQ-021 Full frame (96 clk) -> vsync low for row 4 only; frame_end once, at col 7 row 5; pixel_addr 0..11 across active pixels, then 0 after wrap.
REQ-022 enable dropped for 5 clk at col 2 -> all outputs frozen, pixel_en=0; resume at col 3 with no skipped or doubled count.
REQ-023 n_rst pulsed at row 2 col 5 -> immediate col 0, row 0, pixel_addr 0, hsync/vsync high.
REQ-024 Default params, DIV=2 -> col wraps at 799, row wraps at 524, frame_end every 840000 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, column/row counters, region FSM
// and sync/blanking decode, with a multiplier-free linear pixel address.
module vga_timing_gen #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  output logic              pixel_en,
  output logic [CNT_W-1:0]  col_cnt,
  output logic [CNT_W-1:0]  row_cnt,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [1:0]        h_state,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              line_end,
  output logic              frame_end
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned H_FP_START   = H_ACTIVE;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_BP_START   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_LAST  = (V_SYNC != 0) ? (V_SYNC_START + V_SYNC - 1) : V_SYNC_START;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  // Refuse to build a generator whose counters cannot reach the last column/line.
  if (DIV < 1 || 64'(H_TOTAL) > (64'(1) << CNT_W) || 64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_param_err
    $error("vga_timing_gen: DIV must be >= 1 and CNT_W must hold H_TOTAL-1 and V_TOTAL-1");
  end

  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        hst_q, hst_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic              pe_c, le_c, fe_c;

  // Divider, counters, address and vertical/active decode of the next position.
  always_comb begin
    div_d  = div_q;
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    pe_c   = enable && (div_q == DIV_W'(DIV - 1));
    le_c   = pe_c && (col_q == CNT_W'(H_TOTAL - 1));
    fe_c   = le_c && (row_q == CNT_W'(V_TOTAL - 1));
    if (enable) begin
      div_d = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end
    if (pe_c) begin
      col_d = le_c ? '0 : col_q + CNT_W'(1);
      if (le_c) begin
        row_d = fe_c ? '0 : row_q + CNT_W'(1);
      end
    end
    de_d = (col_d < CNT_W'(H_ACTIVE)) && (row_d < CNT_W'(V_ACTIVE));
    // Address holds through blanking, so the next active pixel is always +1.
    if (pe_c) begin
      if (fe_c) begin
        addr_d = '0;
      end else if (de_d) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
    vsync_d = ((V_SYNC != 0) && (row_d >= CNT_W'(V_SYNC_START)) &&
               (row_d <= CNT_W'(V_SYNC_LAST))) ? VS_POL : ~VS_POL;
  end

  // Horizontal region FSM; empty regions are skipped at the shared boundary column.
  always_comb begin
    hst_d = hst_q;
    if (pe_c) begin
      if (col_d == '0) begin
        hst_d = ST_ACTIVE;
      end else begin
        case (hst_q)
          ST_ACTIVE: if (col_d == CNT_W'(H_FP_START))
                       hst_d = (H_FP != 0) ? ST_FRONT : ((H_SYNC != 0) ? ST_SYNC : ST_BACK);
          ST_FRONT:  if (col_d == CNT_W'(H_SYNC_START))
                       hst_d = (H_SYNC != 0) ? ST_SYNC : ST_BACK;
          ST_SYNC:   if (col_d == CNT_W'(H_BP_START))
                       hst_d = ST_BACK;
          default:   hst_d = hst_q;
        endcase
      end
    end
    hsync_d = (hst_d == ST_SYNC) ? HS_POL : ~HS_POL;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      hst_q   <= ST_ACTIVE;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      hst_q   <= hst_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
    end
  end

  assign pixel_en   = pe_c;
  assign line_end   = le_c;
  assign frame_end  = fe_c;
  assign col_cnt    = col_q;
  assign row_cnt    = row_q;
  assign pixel_addr = addr_q;
  assign h_state    = hst_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;

endmodule
